// File: rtl/platform_scroller.sv
// platform_scroller: vertical scroll engine for the platform field.
//   Once per frame it shifts every platform row down by a clamped scroll
//   amount, then walks the rows one per cycle and recycles any row that has
//   fallen past the bottom back to the top with a fresh random pattern.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   frame_start        one-cycle per-frame request, samples scroll_amount
//   scroll_amount[4:0] requested downward scroll in pixels
//   random[15:0]       LFSR bits; low COLS bits become a recycled row pattern
//   row_y              signed 11-bit top y per row
//   row_active         per-platform enables per row
//   busy               update in progress
//   frame_done         one-cycle pulse at end of each accepted update
//   overrun            sticky: frame_start seen while busy
//   score              saturating total of pixels scrolled

// Per-row state: y position and platform pattern for one row.
module platform_scroller_row #(
  parameter int                ROWS         = 31,
  parameter int                COLS         = 3,
  parameter int                ROW_PITCH    = 30,
  parameter int                BOTTOM_LIMIT = 768,
  parameter logic signed [10:0] INIT_Y      = '0,
  parameter logic [COLS-1:0]   INIT_ACT     = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                shift_en,
  input  logic [4:0]          amt,
  input  logic                rec_en,
  input  logic [COLS-1:0]     pattern,
  output logic signed [10:0]  y,
  output logic [COLS-1:0]     active
);
  localparam logic signed [10:0] LIMIT = 11'(BOTTOM_LIMIT);
  localparam logic signed [10:0] WRAP  = 11'(ROWS * ROW_PITCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y      <= INIT_Y;
      active <= INIT_ACT;
    end else if (shift_en) begin
      y <= y + $signed({6'b0, amt});
    end else if (rec_en && (y >= LIMIT)) begin
      y      <= y - WRAP;
      active <= pattern;
    end
  end
endmodule

module platform_scroller #(
  parameter int ROWS         = 31,
  parameter int COLS         = 3,
  parameter int ROW_PITCH    = 30,
  parameter int TOP_Y        = -162,
  parameter int BOTTOM_LIMIT = 768,
  parameter int MAX_STEP     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_start,
  input  logic [4:0]                 scroll_amount,
  input  logic [15:0]                random,
  output logic [ROWS-1:0][10:0]      row_y,
  output logic [ROWS-1:0][COLS-1:0]  row_active,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       overrun,
  output logic [15:0]                score
);
  localparam int PW = (ROWS > 1) ? $clog2(ROWS) : 1;
  // Middle column only: guarantees a recycled row is always reachable.
  localparam logic [COLS-1:0] MID = COLS'(1) << (COLS / 2);

  typedef enum logic [1:0] {IDLE, SHIFT, RECYCLE, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q;
  logic [4:0]      amt_q;
  logic [4:0]      amt_clamped;
  logic [COLS-1:0] pattern;
  logic [16:0]     score_sum;
  logic            unused_random;

  assign amt_clamped = (scroll_amount > 5'(MAX_STEP)) ? 5'(MAX_STEP) : scroll_amount;
  assign pattern     = (random[COLS-1:0] == '0) ? MID : random[COLS-1:0];
  assign score_sum   = {1'b0, score} + {12'b0, amt_q};
  assign unused_random = ^random[15:COLS];

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start) state_d = (amt_clamped != '0) ? SHIFT : DONE;
      SHIFT:   state_d = RECYCLE;
      RECYCLE: if (ptr_q == PW'(ROWS - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // datapath / registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      amt_q      <= '0;
      score      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      busy       <= (state_d != IDLE);
      frame_done <= (state_d == DONE);
      if (state_q == IDLE && frame_start) amt_q <= amt_clamped;
      if (state_q != IDLE && frame_start) overrun <= 1'b1;
      if (state_q == SHIFT) begin
        ptr_q <= '0;
        score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
      end else if (state_q == RECYCLE) begin
        ptr_q <= ptr_q + PW'(1);
      end
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    platform_scroller_row #(
      .ROWS(ROWS), .COLS(COLS), .ROW_PITCH(ROW_PITCH), .BOTTOM_LIMIT(BOTTOM_LIMIT),
      .INIT_Y(11'(TOP_Y + i * ROW_PITCH)),
      .INIT_ACT((i % 2 == 0) ? MID : '0)
    ) u_row (
      .clk      (clk),
      .rst      (rst),
      .shift_en (state_q == SHIFT),
      .amt      (amt_q),
      .rec_en   (state_q == RECYCLE && ptr_q == PW'(i)),
      .pattern  (pattern),
      .y        (row_y[i]),
      .active   (row_active[i])
    );
  end
endmodule

// File: tb/tb_platform_scroller.sv
module tb_platform_scroller;
  localparam int ROWS = 31;
  localparam int COLS = 3;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      frame_start = 1'b0;
  logic [4:0]                scroll_amount = '0;
  logic [15:0]               random = '0;
  logic [ROWS-1:0][10:0]     row_y;
  logic [ROWS-1:0][COLS-1:0] row_active;
  logic                      busy, frame_done, overrun;
  logic [15:0]               score;

  platform_scroller dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .scroll_amount(scroll_amount),
    .random(random), .row_y(row_y), .row_active(row_active), .busy(busy),
    .frame_done(frame_done), .overrun(overrun), .score(score)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string name;
    int    start;
    int    lat;
    int    y0;
    int    idx;
    int    y_idx;
    int    act_idx;
    int    score;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: every frame_done pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (!rst && frame_done) begin
      if (q.size() == 0) begin
        check("unexpected_frame_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check({e.name, "_latency"}, cyc - e.start, e.lat);
        check({e.name, "_row_y0"}, int'($signed(row_y[0])), e.y0);
        check({e.name, "_row_y_idx"}, int'($signed(row_y[e.idx])), e.y_idx);
        check({e.name, "_row_act_idx"}, int'(row_active[e.idx]), e.act_idx);
        check({e.name, "_score"}, int'(score), e.score);
      end
    end
  end

  // called at a negedge; drives frame_start for one cycle
  task automatic issue(input string name, input int amt, input logic [15:0] rnd,
                       input bit push, input int lat, input int y0, input int idx,
                       input int y_idx, input int act_idx, input int sc);
    exp_t e;
    frame_start   = 1'b1;
    scroll_amount = 5'(amt);
    random        = rnd;
    if (push) begin
      e = '{name, cyc, lat, y0, idx, y_idx, act_idx, sc};
      q.push_back(e);
    end
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check({name, "_timeout"}, 1, 0);
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_row_y0", int'($signed(row_y[0])), -162);
    check("rst_row_y30", int'($signed(row_y[30])), 738);
    check("rst_act0", int'(row_active[0]), 3'b010);
    check("rst_act1", int'(row_active[1]), 3'b000);
    check("rst_score", int'(score), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);

    issue("scroll10", 10, 16'h0000, 1, 33, -152, 30, 748, 3'b010, 10);
    check("busy_after_start", int'(busy), 1);
    wait_drain("scroll10");
    check("idle_after_done", int'(busy), 0);

    issue("clamp31", 31, 16'h0000, 1, 33, -136, 30, 764, 3'b010, 26);
    wait_drain("clamp31");

    issue("recycle_5", 4, 16'h0005, 1, 33, -132, 30, -162, 3'b101, 30);
    wait_drain("recycle_5");

    issue("pre_29", 16, 16'h0000, 1, 33, -116, 29, 754, 3'b000, 46);
    wait_drain("pre_29");

    issue("recycle_zero", 14, 16'h0000, 1, 33, -102, 29, -162, 3'b010, 60);
    wait_drain("recycle_zero");

    issue("amt_zero", 0, 16'h0000, 1, 1, -102, 29, -162, 3'b010, 60);
    wait_drain("amt_zero");
    check("no_overrun_yet", int'(overrun), 0);

    // second request mid-update must be dropped and flag overrun
    issue("overrun", 2, 16'h0000, 1, 33, -100, 28, 740, 3'b010, 62);
    repeat (4) @(negedge clk);
    issue("ignored", 10, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    wait_drain("overrun");
    check("overrun_set", int'(overrun), 1);

    // reset in the middle of the recycle walk
    issue("aborted", 5, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    repeat (13) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_row_y0", int'($signed(row_y[0])), -162);
    check("midrst_row_y30", int'($signed(row_y[30])), 738);
    check("midrst_act1", int'(row_active[1]), 3'b000);
    check("midrst_score", int'(score), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_frame_done", int'(frame_done), 0);
    check("midrst_overrun", int'(overrun), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    issue("post_rst", 3, 16'h0000, 1, 33, -159, 30, 741, 3'b010, 3);
    wait_drain("post_rst");
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/platform_scroller.md
PLATFORM_SCROLLER -- requirements
Module: platform_scroller

Interface
REQ-001 Parameters (name, default, meaning): ROWS, 31, platform rows; COLS, 3, platforms per row; ROW_PITCH, 30, vertical row spacing in pixels; TOP_Y, -162, row 0 y after reset; BOTTOM_LIMIT, 768, y at which a row is recycled; MAX_STEP, 16, per-frame scroll clamp.
REQ-002 clk  input  1  single system clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 frame_start  input  1  one-cycle pulse, once per video frame.
REQ-005 scroll_amount  input  5  unsigned pixels of downward scroll requested, sampled with frame_start.
REQ-006 random  input  16  LFSR bits from the random coin block.
REQ-007 row_y  output  ROWS x 11  signed top y of each row, feeds the platform renderer.
REQ-008 row_active  output  ROWS x COLS  per-platform activation, feeds the platform renderer.
REQ-009 busy  output  1  high while an update is in progress.
REQ-010 frame_done  output  1  one-cycle pulse at end of each accepted update.
REQ-011 overrun  output  1  sticky flag, frame_start arrived while busy.
REQ-012 score  output  16  total pixels scrolled, saturating.

Function
REQ-013 States: IDLE, SHIFT, RECYCLE, DONE.
REQ-014 IDLE with frame_start=1: latch amt = min(scroll_amount, MAX_STEP); go SHIFT if amt>0, else DONE.
REQ-015 SHIFT (1 cycle): every row_y[i] += amt (11-bit signed, no overflow possible within limits); score += amt, saturating at 65535; go RECYCLE with row pointer = 0.
REQ-016 RECYCLE (exactly ROWS cycles, one row per cycle, pointer 0..ROWS-1): if row_y[ptr] >= BOTTOM_LIMIT (signed compare), row_y[ptr] -= ROWS*ROW_PITCH and row_active[ptr] = random[COLS-1:0] sampled in that cycle; else the row is unchanged.
REQ-017 Recycled pattern of all zeros is replaced by the middle column only (3'b010 for COLS=3) so every new row is reachable.
REQ-018 After pointer ROWS-1 go DONE; DONE lasts 1 cycle with frame_done=1, then IDLE.
REQ-019 Latency: frame_start at cycle 0 with amt>0 gives frame_done at cycle ROWS+2; with amt=0, frame_done at cycle 1 and no output change.
REQ-020 busy = 1 in SHIFT, RECYCLE, DONE; 0 in IDLE.
REQ-021 frame_start while busy is ignored (no queuing) and sets overrun; overrun clears only on rst.
REQ-022 row_y and row_active change only in SHIFT/RECYCLE; outputs are registered.

Reset
REQ-023 rst asserted at any time, including mid-RECYCLE, immediately forces: state IDLE, ptr 0, row_y[i] = TOP_Y + i*ROW_PITCH, row_active[i] = middle column only for even i and 0 for odd i, busy=0, frame_done=0, overrun=0, score=0.
REQ-024 First frame_start is honoured on the first clock edge after rst deasserts.

Verification
REQ-025 Reset -> row_y[0]=-162, row_y[30]=738, row_active[0]=010, row_active[1]=000, score=0, busy=0.
REQ-026 frame_start, scroll_amount=10 -> busy next cycle, row_y[30]=748, no recycle, frame_done at cycle 33, score=10.
REQ-027 scroll_amount=31 -> clamped: row_y[0] +16, score +16.
REQ-028 Scroll row 30 to exactly 768 with random=0x0005 -> row_y[30]=-162, row_active[30]=101; repeat with random=0x0000 -> row_active=010.
REQ-029 frame_start at cycle 5 of an update -> ignored, overrun=1, frame_done still at cycle 33 of the first update.
REQ-030 rst pulse during RECYCLE (ptr=12) -> all outputs at reset values within the same cycle, no frame_done.
